// File: rtl/ipv4_header_builder.sv
// ipv4_header_builder
// Builds one 20-byte option-less IPv4 header for every accepted payload length.
// The per-packet fields are captured at the length handshake. The header checksum
// is formed in two register stages (raw sum, then fold and invert). The header is
// then streamed MSB-first as 20/AXIS_BYTES beats.
module ipv4_header_builder #(
    parameter int          AXIS_BYTES = 1,
    parameter logic [7:0]  TTL        = 8'd64,
    parameter logic [15:0] ID_INIT    = 16'h0000
) (
    input  logic                      clk,
    input  logic                      sresetn,
    input  logic [31:0]               src_ip,
    input  logic [31:0]               dest_ip,
    input  logic [7:0]                protocol,
    input  logic [7:0]                tos,
    input  logic                      dont_frag,
    output logic                      payload_length_axis_tready,
    input  logic                      payload_length_axis_tvalid,
    input  logic                      payload_length_axis_tlast,
    input  logic [15:0]               payload_length_axis_tdata,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
    output logic                      len_err
);

    localparam int         BW        = 8 * AXIS_BYTES;
    localparam int         BEATS     = 20 / AXIS_BYTES;
    localparam int         HDR_W     = 160;
    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    // Only byte-aligned divisors of the 20-byte header are supported.
    if (AXIS_BYTES != 1 && AXIS_BYTES != 2 && AXIS_BYTES != 4) begin : g_bad_width
        $error("ipv4_header_builder: AXIS_BYTES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FOLD = 2'd2,
        S_SEND = 2'd3
    } state_t;

    // Total length saturates at the largest value the 16-bit field can carry.
    function automatic logic [15:0] sat_len(input logic [16:0] total);
        return total[16] ? 16'hFFFF : total[15:0];
    endfunction

    // Two end-around-carry folds of the 20-bit sum, then the ones-complement.
    // After the first fold the value is at most 0x1000E, so the second fold
    // cannot produce another carry.
    function automatic logic [15:0] fold_csum(input logic [19:0] raw);
        logic [16:0] f1;
        logic [15:0] f2;
        f1 = {1'b0, raw[15:0]} + {13'b0, raw[19:16]};
        f2 = f1[15:0] + {15'b0, f1[16]};
        return ~f2;
    endfunction

    // Control state
    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [15:0] r_id;

    // Per-packet snapshot (data path, not reset)
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [7:0]  r_proto;
    logic [7:0]  r_tos;
    logic        r_df;
    logic [15:0] r_tot;
    logic        r_sat;

    // Checksum pipeline registers
    logic [19:0] r_sum_p1;
    logic [15:0] r_csum_p2;

    // Combinational signals
    logic              w_tready;
    logic              w_tvalid;
    logic              w_tlast;
    logic              w_len_hs;
    logic              w_out_hs;
    logic [16:0]       w_tot17;
    logic [15:0]       w_w0;
    logic [15:0]       w_w3;
    logic [15:0]       w_w4;
    logic [19:0]       w_sum_p0;
    logic [HDR_W-1:0]  w_hdr;
    logic [8:0]        w_shamt;
    logic [HDR_W-1:0]  w_shifted;
    logic [BW-1:0]     w_beat;
    logic              w_unused;

    // The length stream's tlast carries no meaning for a single-word length.
    assign w_unused = payload_length_axis_tlast;

    assign w_tot17 = {1'b0, payload_length_axis_tdata} + 17'd20;

    assign w_w0 = {4'h4, 4'h5, r_tos};
    assign w_w3 = {1'b0, r_df, 14'b0};
    assign w_w4 = {TTL, r_proto};

    // Stage p0: raw ones-complement sum of the nine non-checksum words
    assign w_sum_p0 = {4'b0, w_w0}         + {4'b0, r_tot}
                    + {4'b0, r_id}         + {4'b0, w_w3}
                    + {4'b0, w_w4}
                    + {4'b0, r_src[31:16]} + {4'b0, r_src[15:0]}
                    + {4'b0, r_dst[31:16]} + {4'b0, r_dst[15:0]};

    assign w_hdr = {w_w0, r_tot, r_id, w_w3, w_w4, r_csum_p2, r_src, r_dst};

    // The current beat is taken from the top lane after shifting the header
    // left by the number of bits already sent.
    assign w_shamt   = 9'(r_cnt) * 9'(BW);
    assign w_shifted = w_hdr << w_shamt;
    assign w_beat    = w_shifted[HDR_W-1 -: BW];

    // Next-state and handshake decode
    always_comb begin
        w_next   = r_state;
        w_tready = 1'b0;
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        w_len_hs = 1'b0;
        w_out_hs = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tready = 1'b1;
                if (payload_length_axis_tvalid) begin
                    w_len_hs = 1'b1;
                    w_next   = S_CALC;
                end
            end
            S_CALC: w_next = S_FOLD;
            S_FOLD: w_next = S_SEND;
            S_SEND: begin
                w_tvalid = 1'b1;
                w_tlast  = (r_cnt == LAST_BEAT);
                if (axis_o_tready) begin
                    w_out_hs = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Beat counter and identification; id advances once per completed header
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_cnt <= 5'd0;
            r_id  <= ID_INIT;
        end else if (r_state == S_FOLD) begin
            r_cnt <= 5'd0;
        end else if (w_out_hs) begin
            if (r_cnt == LAST_BEAT) begin
                r_cnt <= 5'd0;
                r_id  <= r_id + 16'd1;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Snapshot of the per-packet fields at the length handshake
    always_ff @(posedge clk) begin
        if (w_len_hs) begin
            r_src   <= src_ip;
            r_dst   <= dest_ip;
            r_proto <= protocol;
            r_tos   <= tos;
            r_df    <= dont_frag;
            r_tot   <= sat_len(w_tot17);
            r_sat   <= w_tot17[16];
        end
    end

    // Stage p1: raw sum registered in CALC
    always_ff @(posedge clk) begin
        if (r_state == S_CALC) begin
            r_sum_p1 <= w_sum_p0;
        end
    end

    // Stage p2: folded, inverted checksum registered in FOLD
    always_ff @(posedge clk) begin
        if (r_state == S_FOLD) begin
            r_csum_p2 <= fold_csum(r_sum_p1);
        end
    end

    // tready is forced low while reset is held so no length is taken then.
    assign payload_length_axis_tready = w_tready & sresetn;
    assign axis_o_tvalid              = w_tvalid;
    assign axis_o_tlast               = w_tlast;
    assign axis_o_tdata               = w_tvalid ? w_beat : '0;
    assign len_err                    = (r_state == S_CALC) && r_sat;

endmodule

// File: tb/tb_ipv4_header_builder.sv
// Testbench for ipv4_header_builder. Three instances cover the three widths:
// AXIS_BYTES=1, AXIS_BYTES=4, and AXIS_BYTES=2 with ID_INIT=FFFF. A table of
// hand-computed headers is run through them, followed by a reset-during-header
// sequence.
module tb_ipv4_header_builder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sresetn;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [7:0]  protocol;
    logic [7:0]  tos;
    logic        dont_frag;
    logic [15:0] len_data;
    logic        len_last;

    logic [2:0]  lv;
    logic [2:0]  ordy;
    logic [2:0]  ltr;
    logic [2:0]  ov;
    logic [2:0]  ol;
    logic [2:0]  le;
    logic [7:0]  d0;
    logic [31:0] d1;
    logic [15:0] d2;

    int n_cmp  = 0;
    int n_fail = 0;

    ipv4_header_builder #(.AXIS_BYTES(1)) u_b1 (
        .clk(clk), .sresetn(sresetn), .src_ip(src_ip), .dest_ip(dest_ip),
        .protocol(protocol), .tos(tos), .dont_frag(dont_frag),
        .payload_length_axis_tready(ltr[0]), .payload_length_axis_tvalid(lv[0]),
        .payload_length_axis_tlast(len_last), .payload_length_axis_tdata(len_data),
        .axis_o_tready(ordy[0]), .axis_o_tvalid(ov[0]), .axis_o_tlast(ol[0]),
        .axis_o_tdata(d0), .len_err(le[0])
    );

    ipv4_header_builder #(.AXIS_BYTES(4)) u_b4 (
        .clk(clk), .sresetn(sresetn), .src_ip(src_ip), .dest_ip(dest_ip),
        .protocol(protocol), .tos(tos), .dont_frag(dont_frag),
        .payload_length_axis_tready(ltr[1]), .payload_length_axis_tvalid(lv[1]),
        .payload_length_axis_tlast(len_last), .payload_length_axis_tdata(len_data),
        .axis_o_tready(ordy[1]), .axis_o_tvalid(ov[1]), .axis_o_tlast(ol[1]),
        .axis_o_tdata(d1), .len_err(le[1])
    );

    ipv4_header_builder #(.AXIS_BYTES(2), .ID_INIT(16'hFFFF)) u_b2 (
        .clk(clk), .sresetn(sresetn), .src_ip(src_ip), .dest_ip(dest_ip),
        .protocol(protocol), .tos(tos), .dont_frag(dont_frag),
        .payload_length_axis_tready(ltr[2]), .payload_length_axis_tvalid(lv[2]),
        .payload_length_axis_tlast(len_last), .payload_length_axis_tdata(len_data),
        .axis_o_tready(ordy[2]), .axis_o_tvalid(ov[2]), .axis_o_tlast(ol[2]),
        .axis_o_tdata(d2), .len_err(le[2])
    );

    typedef struct {
        int          sel;
        logic [15:0] plen;
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  proto;
        logic [7:0]  tos;
        logic        df;
        logic        stall;
        logic [15:0] id;
        logic [15:0] tot;
        logic [15:0] csum;
        int          lerr;
    } vec_t;

    vec_t vt[7];

    function automatic int ab_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] od_of(input int sel);
        case (sel)
            0:       return {24'b0, d0};
            1:       return d1;
            default: return {16'b0, d2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Offers one length to instance v.sel and collects the whole header.
    task automatic run_hdr(input vec_t v);
        int          sel;
        int          bw;
        int          beats;
        int          cyc;
        int          nb;
        int          first;
        int          lerr_n;
        logic        lerr_calc;
        logic        busy_bad;
        logic        drop_bad;
        logic        hold;
        logic [31:0] hd;
        logic        hl;
        logic [159:0] exp;
        logic [159:0] tmp;
        logic [31:0] expw;
        sel   = v.sel;
        bw    = 8 * ab_of(sel);
        beats = 20 / ab_of(sel);
        exp   = {8'h45, v.tos, v.tot, v.id, 1'b0, v.df, 14'b0, 8'h40, v.proto,
                 v.csum, v.src, v.dst};
        @(negedge clk);
        src_ip    = v.src;
        dest_ip   = v.dst;
        protocol  = v.proto;
        tos       = v.tos;
        dont_frag = v.df;
        len_data  = v.plen;
        lv[sel]   = 1'b1;
        ordy[sel] = 1'b1;
        check($sformatf("v%0d_tready_idle", sel), 32'(ltr[sel]), 32'd1);
        @(posedge clk);
        cyc = 0; nb = 0; first = -1; lerr_n = 0; lerr_calc = 1'b0;
        busy_bad = 1'b0; drop_bad = 1'b0; hold = 1'b0; hd = '0; hl = 1'b0;
        while (nb < beats && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                lv[sel]   = 1'b0;
                src_ip    = $urandom;
                dest_ip   = $urandom;
                protocol  = 8'($urandom);
                tos       = 8'($urandom);
                dont_frag = ~dont_frag;
                len_data  = 16'($urandom);
                lerr_calc = le[sel];
            end
            if (le[sel]) lerr_n++;
            if (ltr[sel]) busy_bad = 1'b1;
            if (hold) begin
                check("stall_valid", 32'(ov[sel]), 32'd1);
                check("stall_data", od_of(sel), hd);
                check("stall_last", 32'(ol[sel]), 32'(hl));
            end
            ordy[sel] = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = 1'b0;
            if (ov[sel]) begin
                if (first < 0) first = cyc;
                if (ordy[sel]) begin
                    tmp  = exp << (nb * bw);
                    expw = tmp[159:128] >> (32 - bw);
                    check($sformatf("hdr_id%0h_beat%0d_data", v.id, nb), od_of(sel), expw);
                    check($sformatf("hdr_id%0h_beat%0d_last", v.id, nb), 32'(ol[sel]),
                          32'(nb == beats - 1));
                    nb++;
                end else begin
                    hold = 1'b1;
                    hd   = od_of(sel);
                    hl   = ol[sel];
                end
            end else if (first >= 0) begin
                drop_bad = 1'b1;
            end
        end
        check("beats_done", 32'(nb), 32'(beats));
        check("first_valid_latency", 32'(first), 32'd3);
        check("len_err_pulses", 32'(lerr_n), 32'(v.lerr));
        check("len_err_in_calc", 32'(lerr_calc), 32'(v.lerr));
        check("tready_low_busy", 32'(busy_bad), 32'd0);
        check("tvalid_no_gap", 32'(drop_bad), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int cyc;
        vt[0] = '{0, 16'd8,     32'hC0A80101, 32'hC0A80102, 8'h11, 8'h00, 1'b1, 1'b0,
                  16'h0000, 16'h001C, 16'hB77D, 0};
        vt[1] = '{0, 16'd8,     32'hC0A80101, 32'hC0A80102, 8'h11, 8'h00, 1'b1, 1'b0,
                  16'h0001, 16'h001C, 16'hB77C, 0};
        vt[2] = '{1, 16'd8,     32'hC0A80101, 32'hC0A80102, 8'h11, 8'h00, 1'b1, 1'b1,
                  16'h0000, 16'h001C, 16'hB77D, 0};
        vt[3] = '{0, 16'd65515, 32'hC0A80101, 32'hC0A80102, 8'h11, 8'h00, 1'b1, 1'b0,
                  16'h0002, 16'hFFFF, 16'hB797, 0};
        vt[4] = '{0, 16'd65516, 32'hC0A80101, 32'hC0A80102, 8'h11, 8'h00, 1'b1, 1'b0,
                  16'h0003, 16'hFFFF, 16'hB796, 1};
        vt[5] = '{2, 16'd100,   32'h0A000001, 32'h0A000002, 8'h06, 8'hB8, 1'b0, 1'b0,
                  16'hFFFF, 16'h0078, 16'h65C6, 0};
        vt[6] = '{2, 16'd0,     32'h0A000001, 32'h0A000002, 8'h06, 8'hB8, 1'b0, 1'b0,
                  16'h0000, 16'h0014, 16'h662A, 0};

        sresetn = 1'b0; lv = '0; ordy = '0; len_last = 1'b0;
        src_ip = '0; dest_ip = '0; protocol = '0; tos = '0; dont_frag = 1'b0; len_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d_tvalid", s), 32'(ov[s]), 32'd0);
            check($sformatf("rst%0d_tlast", s), 32'(ol[s]), 32'd0);
            check($sformatf("rst%0d_tdata", s), od_of(s), 32'd0);
            check($sformatf("rst%0d_tready", s), 32'(ltr[s]), 32'd0);
            check($sformatf("rst%0d_len_err", s), 32'(le[s]), 32'd0);
        end
        sresetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_hdr(vt[i]);
        end

        // Reset while beat 7 of a byte-wide header is on the bus.
        @(negedge clk);
        src_ip = 32'hC0A80101; dest_ip = 32'hC0A80102; protocol = 8'h11;
        tos = 8'h00; dont_frag = 1'b1; len_data = 16'd8;
        lv[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk);
        nb = 0; cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            lv[0] = 1'b0;
            if (ov[0]) begin
                if (nb == 7) break;
                nb++;
            end
        end
        check("abort_reached_beat7", 32'(nb), 32'd7);
        sresetn = 1'b0;
        @(negedge clk);
        check("abort_tvalid", 32'(ov[0]), 32'd0);
        check("abort_tlast", 32'(ol[0]), 32'd0);
        check("abort_tdata", od_of(0), 32'd0);
        check("abort_tready", 32'(ltr[0]), 32'd0);
        check("abort_len_err", 32'(le[0]), 32'd0);
        sresetn = 1'b1;
        run_hdr(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
